// File: rtl/regfile_pkg.sv
// Shared defaults and index-width helper for the parametrised register file.
package regfile_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_NUM_REGS   = 32;

    function automatic int addr_width(input int num_regs);
        return (num_regs > 1) ? $clog2(num_regs) : 1;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register plus a registered busy count.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NUM_REGS   = DEFAULT_NUM_REGS,
    parameter int ZERO_REG   = 1,
    parameter int ADDR_WIDTH = addr_width(NUM_REGS)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  set_i,
    input  logic [ADDR_WIDTH-1:0] set_idx_i,
    input  logic                  clr_i,
    input  logic [ADDR_WIDTH-1:0] clr_idx_i,
    input  logic [ADDR_WIDTH-1:0] rd_idx_a_i,
    input  logic [ADDR_WIDTH-1:0] rd_idx_b_i,
    output logic                  busy_a_o,
    output logic                  busy_b_o,
    output logic [ADDR_WIDTH:0]   count_o
);

    localparam int CW = ADDR_WIDTH + 1;

    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [CW-1:0]       count_q, count_d;
    logic                set_en, inc, dec;

    assign set_en = set_i && !((ZERO_REG != 0) && (set_idx_i == '0));

    always_comb begin
        busy_d = busy_q;
        if (clr_i)
            busy_d[clr_idx_i] = 1'b0;
        // Set is applied last so a freshly issued producer wins over a retiring one.
        if (set_en)
            busy_d[set_idx_i] = 1'b1;
    end

    assign inc = set_en && !busy_q[set_idx_i];
    assign dec = clr_i && busy_q[clr_idx_i] && !(set_en && (set_idx_i == clr_idx_i));

    always_comb begin
        count_d = count_q + CW'(inc) - CW'(dec);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    assign busy_a_o = busy_q[rd_idx_a_i];
    assign busy_b_o = busy_q[rd_idx_b_i];
    assign count_o  = count_q;

endmodule

// File: rtl/regfile_param_sb.sv
// Two-read / one-write register file with same-cycle bypass and pending-write scoreboard.
module regfile_param_sb
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int NUM_REGS   = DEFAULT_NUM_REGS,
    parameter int ADDR_WIDTH = addr_width(NUM_REGS),
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                  clock,
    input  logic                  ctrl_reset_n,
    input  logic                  ctrl_writeEnable,
    input  logic [ADDR_WIDTH-1:0] ctrl_writeReg,
    input  logic [DATA_WIDTH-1:0] data_writeReg,
    input  logic [ADDR_WIDTH-1:0] ctrl_readRegA,
    input  logic [ADDR_WIDTH-1:0] ctrl_readRegB,
    output logic [DATA_WIDTH-1:0] data_readRegA,
    output logic [DATA_WIDTH-1:0] data_readRegB,
    input  logic                  ctrl_busySet,
    input  logic [ADDR_WIDTH-1:0] ctrl_busyReg,
    output logic                  busy_readRegA,
    output logic                  busy_readRegB,
    output logic [ADDR_WIDTH:0]   busy_count
);

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q;
    logic wr_en;
    logic zero_a, zero_b;
    logic fwd_a, fwd_b;
    logic sb_busy_a, sb_busy_b;

    assign wr_en  = ctrl_writeEnable && !((ZERO_REG != 0) && (ctrl_writeReg == '0));
    assign zero_a = (ZERO_REG != 0) && (ctrl_readRegA == '0);
    assign zero_b = (ZERO_REG != 0) && (ctrl_readRegB == '0);

    // Forwarding is gated by reset so every output reads 0 while reset is held.
    assign fwd_a = (BYPASS != 0) && ctrl_reset_n && wr_en && (ctrl_writeReg == ctrl_readRegA);
    assign fwd_b = (BYPASS != 0) && ctrl_reset_n && wr_en && (ctrl_writeReg == ctrl_readRegB);

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n)
            regs_q <= '0;
        else if (wr_en)
            regs_q[ctrl_writeReg] <= data_writeReg;
    end

    always_comb begin
        data_readRegA = regs_q[ctrl_readRegA];
        data_readRegB = regs_q[ctrl_readRegB];
        if (zero_a)
            data_readRegA = '0;
        else if (fwd_a)
            data_readRegA = data_writeReg;
        if (zero_b)
            data_readRegB = '0;
        else if (fwd_b)
            data_readRegB = data_writeReg;
    end

    regfile_scoreboard #(
        .NUM_REGS   (NUM_REGS),
        .ZERO_REG   (ZERO_REG),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_sb (
        .clk_i      (clock),
        .rst_ni     (ctrl_reset_n),
        .set_i      (ctrl_busySet),
        .set_idx_i  (ctrl_busyReg),
        .clr_i      (ctrl_writeEnable),
        .clr_idx_i  (ctrl_writeReg),
        .rd_idx_a_i (ctrl_readRegA),
        .rd_idx_b_i (ctrl_readRegB),
        .busy_a_o   (sb_busy_a),
        .busy_b_o   (sb_busy_b),
        .count_o    (busy_count)
    );

    // A forwarded value is already available, so it must not stall the reader.
    assign busy_readRegA = sb_busy_a && !fwd_a;
    assign busy_readRegB = sb_busy_b && !fwd_b;

endmodule

// File: tb/tb_regfile_param_sb.sv
// Directed bench for regfile_param_sb: a bypassing instance and a non-bypassing twin.
module tb_regfile_param_sb;

    logic        clock = 1'b0;
    logic        rst_n;
    logic        we;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic [4:0]  ra, rb;
    logic        bset;
    logic [4:0]  breg;

    logic [31:0] a1, b1, a0, b0;
    logic        ba1, bb1, ba0, bb0;
    logic [5:0]  cnt1, cnt0;

    int tests  = 0;
    int failed = 0;

    always #5 clock = ~clock;

    regfile_param_sb #(.BYPASS(1)) dut (
        .clock(clock), .ctrl_reset_n(rst_n),
        .ctrl_writeEnable(we), .ctrl_writeReg(wreg), .data_writeReg(wdata),
        .ctrl_readRegA(ra), .ctrl_readRegB(rb),
        .data_readRegA(a1), .data_readRegB(b1),
        .ctrl_busySet(bset), .ctrl_busyReg(breg),
        .busy_readRegA(ba1), .busy_readRegB(bb1), .busy_count(cnt1)
    );

    regfile_param_sb #(.BYPASS(0)) dut_nb (
        .clock(clock), .ctrl_reset_n(rst_n),
        .ctrl_writeEnable(we), .ctrl_writeReg(wreg), .data_writeReg(wdata),
        .ctrl_readRegA(ra), .ctrl_readRegB(rb),
        .data_readRegA(a0), .data_readRegB(b0),
        .ctrl_busySet(bset), .ctrl_busyReg(breg),
        .busy_readRegA(ba0), .busy_readRegB(bb0), .busy_count(cnt0)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; we = 1'b0; wreg = '0; wdata = '0;
        ra = '0; rb = '0; bset = 1'b0; breg = '0;
        #3;
        chk("rst_a", a1, 0);
        chk("rst_cnt", cnt1, 0);
        #10 rst_n = 1'b1;
        tick();

        // Every index on both ports after reset
        for (int i = 0; i < 32; i++) begin
            ra = 5'(i);
            rb = 5'(31 - i);
            #1;
            chk("init_a", a1, 0);
            chk("init_b", b1, 0);
            chk("init_busy", {ba1, bb1, ba0, bb0}, 0);
        end
        chk("init_cnt", cnt1, 0);

        // Same-cycle bypass versus no bypass
        tick();
        we = 1'b1; wreg = 5'd5; wdata = 32'hDEADBEEF; ra = 5'd5;
        #1;
        chk("byp_a", a1, 32'hDEADBEEF);
        chk("nobyp_a", a0, 0);
        tick();
        we = 1'b0;
        #1;
        chk("byp_a_next", a1, 32'hDEADBEEF);
        chk("nobyp_a_next", a0, 32'hDEADBEEF);

        // Hardwired zero register ignores writes and busy sets
        we = 1'b1; wreg = 5'd0; wdata = 32'h1234; bset = 1'b1; breg = 5'd0; ra = 5'd0;
        #1;
        chk("r0_a_same", a1, 0);
        chk("r0_busy_same", ba1, 0);
        tick();
        we = 1'b0; bset = 1'b0;
        #1;
        chk("r0_a", a1, 0);
        chk("r0_a_nb", a0, 0);
        chk("r0_busy", ba1, 0);
        chk("r0_cnt", cnt1, 0);

        // Reserve r7, hold for three cycles, then write it back
        bset = 1'b1; breg = 5'd7; rb = 5'd7;
        tick();
        bset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("r7_busy", bb1, 1);
            chk("r7_cnt", cnt1, 1);
            if (c < 2) tick();
        end
        tick();
        we = 1'b1; wreg = 5'd7; wdata = 32'h55;
        #1;
        chk("r7_wr_busy", bb1, 0);
        chk("r7_wr_b", b1, 32'h55);
        chk("r7_wr_busy_nb", bb0, 1);
        chk("r7_wr_b_nb", b0, 0);
        chk("r7_wr_cnt", cnt1, 1);
        tick();
        we = 1'b0;
        #1;
        chk("r7_after_cnt", cnt1, 0);
        chk("r7_after_busy", bb1, 0);
        chk("r7_after_b", b1, 32'h55);

        // Set and clear on the same index: set wins
        bset = 1'b1; breg = 5'd9; we = 1'b1; wreg = 5'd9; wdata = 32'hAA; ra = 5'd9;
        #1;
        chk("r9_same_a", a1, 32'hAA);
        chk("r9_same_busy", ba1, 0);
        tick();
        bset = 1'b0; we = 1'b0;
        #1;
        chk("r9_a", a1, 32'hAA);
        chk("r9_busy", ba1, 1);
        chk("r9_cnt", cnt1, 1);

        // Reserve r3 then r4, then reset mid-cycle
        bset = 1'b1; breg = 5'd3;
        tick();
        breg = 5'd4;
        tick();
        bset = 1'b0; ra = 5'd3; rb = 5'd4;
        #1;
        chk("r34_cnt", cnt1, 3);
        chk("r34_busy", {ba1, bb1}, 2'b11);
        ra = 5'd9;
        we = 1'b1; wreg = 5'd9; wdata = 32'h77;
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_a", a1, 0);
        chk("mid_rst_a_nb", a0, 0);
        chk("mid_rst_busy", {ba1, bb1}, 0);
        chk("mid_rst_cnt", cnt1, 0);
        chk("mid_rst_cnt_nb", cnt0, 0);
        we = 1'b0;
        #2 rst_n = 1'b1;
        tick();
        #1;
        chk("post_rst_a", a1, 0);

        // Re-set of a busy register, cross-index set/clear, non-busy write
        bset = 1'b1; breg = 5'd2; ra = 5'd2; rb = 5'd3;
        tick();
        #1 chk("set2_cnt", cnt1, 1);
        tick();
        #1 chk("reset2_cnt", cnt1, 1);
        breg = 5'd3; we = 1'b1; wreg = 5'd2; wdata = 32'h22;
        tick();
        bset = 1'b0;
        #1;
        chk("swap_cnt", cnt1, 1);
        chk("swap_busy", {ba1, bb1}, 2'b01);
        wreg = 5'd6; wdata = 32'h66;
        tick();
        #1 chk("nonbusy_wr_cnt", cnt1, 1);
        wreg = 5'd3; wdata = 32'h33;
        tick();
        we = 1'b0;
        #1;
        chk("final_cnt", cnt1, 0);
        chk("final_b", b1, 32'h33);
        chk("final_a", a1, 32'h22);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/regfile_param_sb.md
Name: regfile_param_sb

Overview:
Parametrised successor to the processor's 32x32 register file. It has the same two read ports and one write port as before, and generalises data width and register count. It adds three things the current file lacks: same-cycle write-to-read bypass, a per-register pending-write scoreboard for multi-cycle units (multdiv, memory), and a pending-count output. It sits between decode (read/issue) and writeback in the pipeline.

Parameters:
DATA_WIDTH, 32, bits per register
NUM_REGS, 32, number of architectural registers (power of two, >=2)
ADDR_WIDTH, $clog2(NUM_REGS), register index width
ZERO_REG, 1, 1 = register 0 is hardwired to zero and never marked busy
BYPASS, 1, 1 = a write in the same cycle is forwarded to matching read ports

Ports:
clock  in  1  single clock, rising edge
ctrl_reset_n  in  1  asynchronous active-low reset
ctrl_writeEnable  in  1  writeback valid
ctrl_writeReg  in  ADDR_WIDTH  writeback index
data_writeReg  in  DATA_WIDTH  writeback data
ctrl_readRegA  in  ADDR_WIDTH  read port A index
ctrl_readRegB  in  ADDR_WIDTH  read port B index
data_readRegA  out  DATA_WIDTH  read port A data
data_readRegB  out  DATA_WIDTH  read port B data
ctrl_busySet  in  1  issue of a long-latency op targeting ctrl_busyReg
ctrl_busyReg  in  ADDR_WIDTH  destination being reserved
busy_readRegA  out  1  register A has an outstanding write
busy_readRegB  out  1  register B has an outstanding write
busy_count  out  ADDR_WIDTH+1  number of registers currently marked busy

Behaviour:
- Reset:
  - ctrl_reset_n low asynchronously clears all registers to 0, all busy bits to 0 and busy_count to 0.
  - All outputs read 0 while reset is held, and the reset takes effect immediately, mid-operation.
- Writes:
  - On a rising edge with ctrl_writeEnable=1, register[ctrl_writeReg] <= data_writeReg.
  - If ZERO_REG=1, writes to index 0 are ignored.
- Reads:
  - Combinational, zero-latency reads of register[ctrl_readRegX].
  - Index 0 returns 0 when ZERO_REG=1.
- Bypass (BYPASS=1):
  - If ctrl_writeEnable=1 and ctrl_writeReg==ctrl_readRegX, and that index is not the hardwired-zero register, data_readRegX = data_writeReg in the same cycle.
  - If BYPASS=0, the read returns the old value until the next edge.
- Scoreboard, one bit per register, updated on the rising edge:
  - ctrl_busySet=1 sets busy[ctrl_busyReg]; it is ignored for index 0 when ZERO_REG=1.
  - ctrl_writeEnable=1 clears busy[ctrl_writeReg].
  - Set and clear on the same index in the same cycle: the set wins (a new producer has been issued).
  - Set on a register that is already busy: the bit stays 1 and busy_count is unchanged.
  - Write to a non-busy register: a normal write with no count change.
- busy_readRegX:
  - Equals busy[ctrl_readRegX], except it is forced to 0 when bypass is forwarding that index in the current cycle. The value is available, so there is no stall.
- busy_count:
  - Registered popcount of the busy bits, updated on the same edge as the bits.
  - Range is 0..NUM_REGS and never wraps.
  - Per cycle it changes by at most +1 or -1, or 0 when set and clear hit different indices in the same cycle.
- Out-of-range indices cannot occur because NUM_REGS is a power of two.

Decomposition:
- Package regfile_pkg holds DATA_WIDTH/NUM_REGS defaults and the ADDR_WIDTH derivation function.
- Sub-module regfile_scoreboard (NUM_REGS, ZERO_REG) holds the busy bit vector, the set/clear priority logic and the busy_count register.
- The storage array and the bypass muxing stay in the top level.

Test Plan:
- Reset, then read every index on both ports -> all data 0, all busy 0, busy_count 0.
- Write 0xDEADBEEF to r5, read A=r5 in the same cycle -> A=0xDEADBEEF with BYPASS=1. With BYPASS=0, A=0 that cycle and 0xDEADBEEF on the next.
- Write 0x1234 to r0 with ZERO_REG=1, and busySet r0 -> A=r0 reads 0, busy_readRegA=0, busy_count stays 0.
- busySet r7, then after 3 cycles write r7=0x55 -> busy_readRegB(r7)=1 for 3 cycles. In the write cycle busy=0 and B=0x55; busy_count goes 1 then 0.
- Same cycle: busySet r9 and write r9=0xAA -> r9=0xAA, busy[r9]=1, busy_count=1.
- busySet r3 and r4 on consecutive cycles, then assert ctrl_reset_n low mid-stream -> all registers 0 and busy_count 0 immediately, without waiting for a clock edge.
